// File: rtl/resilient_stage_ctrl.sv
// Clocked error-resilient pipeline stage: holds one word between req/ack interfaces,
// substitutes the shadow word on a timing-error verdict and stalls for recovery.
module resilient_stage_ctrl #(
  parameter int WIDTH           = 32,
  parameter int RECOVERY_CYCLES = 1,
  parameter int TIMEOUT         = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l_req,
  input  logic [WIDTH-1:0] l_data,
  output logic             l_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack,
  input  logic             err1,
  input  logic             err0,
  input  logic [WIDTH-1:0] shadow_data,
  input  logic             clr_err,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  output logic             fault_sticky
);

  typedef enum logic [1:0] {EMPTY, CHECK, RECOVER, VALID} state_t;

  localparam logic [3:0] REC_LOAD = 4'(RECOVERY_CYCLES - 1);
  localparam logic [3:0] TO_LAST  = 4'(TIMEOUT - 1);

  state_t           state_q;
  logic [WIDTH-1:0] d_q;
  logic [3:0]       t_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_sticky_q, fault_sticky_q;
  logic             in_check, timeout_hit, err_evt, fault_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A forced error fires only when no rail has arrived by the last CHECK cycle.
  assign in_check    = (state_q == CHECK);
  assign timeout_hit = in_check & ~err1 & ~err0 & (t_q == TO_LAST);
  assign err_evt     = (in_check & err1) | timeout_hit;
  assign fault_evt   = (in_check & err1 & err0) | timeout_hit;
  assign cnt_d       = err_evt ? sat_inc(cnt_q) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= EMPTY;
      d_q            <= '0;
      t_q            <= '0;
      cnt_q          <= '0;
      err_sticky_q   <= 1'b0;
      fault_sticky_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (l_req) begin
            d_q     <= l_data;
            t_q     <= '0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (err0 && !err1) begin
            state_q <= VALID;
          end else if (err1) begin
            d_q     <= shadow_data;
            t_q     <= REC_LOAD;
            state_q <= RECOVER;
          end else if (t_q == TO_LAST) begin
            t_q     <= REC_LOAD;
            state_q <= RECOVER;
          end else begin
            t_q <= t_q + 4'd1;
          end
        end
        RECOVER: begin
          if (t_q == 4'd0) state_q <= VALID;
          else             t_q     <= t_q - 4'd1;
        end
        VALID: begin
          if (r_ack) begin
            if (l_req) begin
              d_q     <= l_data;
              t_q     <= '0;
              state_q <= CHECK;
            end else begin
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase

      // Clear takes priority over an error event on the same edge.
      if (clr_err) begin
        cnt_q          <= '0;
        err_sticky_q   <= 1'b0;
        fault_sticky_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        if (err_evt)   err_sticky_q   <= 1'b1;
        if (fault_evt) fault_sticky_q <= 1'b1;
      end
    end
  end

  assign l_ack        = (state_q == EMPTY) | ((state_q == VALID) & r_ack);
  assign r_req        = (state_q == VALID);
  assign r_data       = d_q;
  assign err_count    = cnt_q;
  assign err_sticky   = err_sticky_q;
  assign fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Directed bench for resilient_stage_ctrl (RECOVERY_CYCLES=2, TIMEOUT=4, CNT_W=8).
module tb_resilient_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst, l_req, l_ack, r_req, r_ack, err1, err0, clr_err;
  logic [31:0] l_data, r_data, shadow_data;
  logic [7:0]  err_count;
  logic        err_sticky, fault_sticky;

  int nvec = 0;
  int nerr = 0;

  resilient_stage_ctrl #(
    .WIDTH(32), .RECOVERY_CYCLES(2), .TIMEOUT(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .l_req(l_req), .l_data(l_data), .l_ack(l_ack),
    .r_req(r_req), .r_data(r_data), .r_ack(r_ack), .err1(err1), .err0(err0),
    .shadow_data(shadow_data), .clr_err(clr_err), .err_count(err_count),
    .err_sticky(err_sticky), .fault_sticky(fault_sticky)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; l_req = 1'b1; l_data = 32'hDEADBEEF; r_ack = 1'b0;
    err1 = 1'b0; err0 = 1'b0; shadow_data = '0; clr_err = 1'b0;

    // 1. reset with l_req held high
    step(); step();
    check("rst_l_ack", l_ack, 1);
    check("rst_r_req", r_req, 0);
    check("rst_r_data", r_data, 0);
    check("rst_cnt", err_count, 0);
    check("rst_esticky", err_sticky, 0);
    check("rst_fsticky", fault_sticky, 0);

    // 2. clean transfer
    rst = 1'b0; l_data = 32'hA5A5A5A5; err0 = 1'b1; r_ack = 1'b1;
    step();
    check("t2_check_rreq", r_req, 0);
    check("t2_check_lack", l_ack, 0);
    check("t2_capture", r_data, 32'hA5A5A5A5);
    l_req = 1'b0;
    step();
    check("t2_rreq", r_req, 1);
    check("t2_rdata", r_data, 32'hA5A5A5A5);
    step();
    check("t2_rreq_drop", r_req, 0);
    check("t2_cnt", err_count, 0);
    check("t2_lack_empty", l_ack, 1);

    // 3. error verdict -> shadow word after 2 recovery cycles
    r_ack = 1'b0; l_req = 1'b1; l_data = 32'h0000FFFF; err0 = 1'b0; err1 = 1'b1;
    shadow_data = 32'h12345678;
    step();
    check("t3_capture", r_data, 32'h0000FFFF);
    l_req = 1'b0;
    step();
    check("t3_rec1_rreq", r_req, 0);
    check("t3_shadow", r_data, 32'h12345678);
    check("t3_cnt", err_count, 1);
    check("t3_esticky", err_sticky, 1);
    err1 = 1'b0;
    step();
    check("t3_rec2_rreq", r_req, 0);
    step();
    check("t3_rreq", r_req, 1);
    check("t3_rdata", r_data, 32'h12345678);
    check("t3_fsticky", fault_sticky, 0);
    r_ack = 1'b1;
    step();
    check("t3_pop", r_req, 0);
    r_ack = 1'b0;

    // 4a. timeout with both rails low
    clr_err = 1'b1;
    step();
    check("t4_clr_cnt", err_count, 0);
    check("t4_clr_esticky", err_sticky, 0);
    clr_err = 1'b0; l_req = 1'b1; l_data = 32'hCAFEF00D; shadow_data = 32'hBAD0BAD0;
    step();
    l_req = 1'b0;
    step(); step(); step();
    check("t4_wait_rreq", r_req, 0);
    check("t4_wait_cnt", err_count, 0);
    step();
    check("t4_forced_cnt", err_count, 1);
    check("t4_forced_fault", fault_sticky, 1);
    check("t4_forced_data", r_data, 32'hCAFEF00D);
    step();
    check("t4_rec_rreq", r_req, 0);
    step();
    check("t4_rreq", r_req, 1);
    check("t4_rdata", r_data, 32'hCAFEF00D);
    r_ack = 1'b1;
    step();
    r_ack = 1'b0;

    // 4b. both rails high -> shadow word plus fault
    clr_err = 1'b1;
    step();
    check("t4b_clr_fault", fault_sticky, 0);
    clr_err = 1'b0; l_req = 1'b1; l_data = 32'h11111111;
    shadow_data = 32'h22222222; err1 = 1'b1; err0 = 1'b1;
    step();
    l_req = 1'b0;
    step();
    check("t4b_fault", fault_sticky, 1);
    check("t4b_cnt", err_count, 1);
    err1 = 1'b0; err0 = 1'b0;
    step(); step();
    check("t4b_rreq", r_req, 1);
    check("t4b_rdata", r_data, 32'h22222222);
    r_ack = 1'b1;
    step();
    check("t4b_pop", r_req, 0);

    // 5a. streaming, one word per 2 cycles
    err0 = 1'b1; l_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      l_data = 32'h100 + i;
      step();
      check("t5_check_phase", r_req, 0);
      step();
      check("t5_valid_phase", r_req, 1);
      check("t5_word", r_data, 32'h100 + i);
    end
    l_req = 1'b0;
    step();
    check("t5_drain", r_req, 0);

    // 5b. saturation: event n lands on edge 4n-2 counted from the first capture
    clr_err = 1'b1;
    step();
    clr_err = 1'b0; err0 = 1'b0; err1 = 1'b1; l_req = 1'b1; l_data = 32'h77777777;
    shadow_data = 32'h88888888;
    repeat (38) step();
    check("t5_cnt10", err_count, 10);
    repeat (1203) step();
    check("t5_sat", err_count, 255);
    clr_err = 1'b1;
    step();
    check("t5_clr_wins_cnt", err_count, 0);
    check("t5_clr_wins_sticky", err_sticky, 0);
    clr_err = 1'b0; err1 = 1'b0; l_req = 1'b0;
    step(); step();
    check("t5_last_word", r_data, 32'h88888888);
    step();
    check("t5_empty", l_ack, 1);

    // 6. reset in the middle of RECOVER
    l_req = 1'b1; l_data = 32'h55AA55AA; err1 = 1'b1; shadow_data = 32'h66666666;
    step();
    l_req = 1'b0;
    step();
    check("t6_pre_cnt", err_count, 1);
    rst = 1'b1; err1 = 1'b0;
    step();
    check("t6_rreq", r_req, 0);
    check("t6_lack", l_ack, 1);
    check("t6_rdata", r_data, 0);
    check("t6_cnt", err_count, 0);
    check("t6_esticky", err_sticky, 0);
    rst = 1'b0;
    step(); step();
    check("t6_no_ghost", r_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/resilient_stage_ctrl.md
Name: resilient_stage_ctrl

Overview:
Clocked successor to the asynchronous error-resilient stage controller, parametrised in data width, recovery length and resolution timeout.
It holds one data word between a left (producer) and right (consumer) req/ack interface.
After each capture it waits for a dual-rail timing-error verdict (err1 = error, err0 = no error) from the stage's error-detecting latch.
On error it substitutes the late-sampled shadow word and stalls for a programmable recovery period before presenting data. It also keeps error statistics.

Parameters:
WIDTH, 32, data word width in bits
RECOVERY_CYCLES, 1, stall cycles after an error before r_req; legal range 1..15
TIMEOUT, 4, maximum cycles spent in CHECK waiting for a verdict before forcing an error; legal range 1..15
CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
l_req  in  1  left valid
l_data  in  WIDTH  left data
l_ack  out  1  left ready; transfer occurs when l_req & l_ack are high at a rising edge
r_req  out  1  right valid
r_data  out  WIDTH  right data
r_ack  in  1  right ready; transfer occurs when r_req & r_ack are high at a rising edge
err1  in  1  error rail for the most recently captured word
err0  in  1  no-error rail for the most recently captured word
shadow_data  in  WIDTH  late-sampled corrected word, valid while err1 is high
clr_err  in  1  clears err_count, err_sticky and fault_sticky
err_count  out  CNT_W  number of error/forced-error events, saturating
err_sticky  out  1  set by any error event
fault_sticky  out  1  set by protocol faults: both rails high, or timeout

Behaviour:
- States: EMPTY, CHECK, RECOVER, VALID. Internal state: data register D, timer T (4 bits).
- Reset (rst sampled high): state=EMPTY, D=0, T=0, err_count=0, err_sticky=0, fault_sticky=0. Reset aborts any state, including mid-RECOVER or mid-CHECK; the held word is discarded.
- Output decode (registered state, no combinational path from l_req to r_req):
  - l_ack = (state==EMPTY) | (state==VALID & r_ack).
  - r_req = (state==VALID).
  - r_data = D at all times.
- EMPTY: on l_req, D<=l_data, T<=0, go to CHECK.
- CHECK: r_req=0, l_ack=0. Each edge evaluates the rails:
  - err0 & ~err1: go to VALID.
  - err1 & ~err0: error event. D<=shadow_data; go to RECOVER with T<=RECOVERY_CYCLES-1.
  - err1 & err0: error event plus fault. D<=shadow_data, fault_sticky<=1, go to RECOVER.
  - Neither rail: T<=T+1. If T==TIMEOUT-1, forced error: D unchanged, fault_sticky<=1, err_count increments, go to RECOVER.
- RECOVER: r_req=0. If T==0 go to VALID, else T<=T-1. The RECOVER state lasts exactly RECOVERY_CYCLES cycles.
- VALID: hold D and r_req until r_ack.
  - On r_ack with l_req high: capture the new word the same edge and go to CHECK.
  - On r_ack without l_req: go to EMPTY.
- Latency with an immediate no-error verdict: capture at edge k, r_req high after edge k+1. Peak throughput is one word per 2 cycles.
- Latency with an immediate error verdict: r_req high after edge k+1+RECOVERY_CYCLES.
- Rails are ignored outside CHECK.
- Error event: err_sticky<=1; err_count<=err_count+1, saturating at 2^CNT_W-1 (it never wraps).
- clr_err: counters and stickies go to 0 on the next edge. If an error event occurs on the same edge, clr_err wins and the event is lost. clr_err does not affect the data path.
- Data is never lost or duplicated. Each captured word produces exactly one right transfer: either the original or the shadow word.

Test Plan:
1. Assert rst for 2 cycles with l_req=1 -> l_ack=1, r_req=0, r_data=0, err_count=0, both stickies 0. After rst falls, the first capture occurs on the next edge.
2. l_data=0xA5A5A5A5, err0=1 in the CHECK cycle, r_ack=1 -> r_req high for one cycle exactly 1 edge after capture. r_data=0xA5A5A5A5, err_count=0.
3. RECOVERY_CYCLES=2: l_data=0x0000FFFF, err1=1, shadow_data=0x12345678 -> r_req rises 3 edges after capture. r_data=0x12345678, err_count=1, err_sticky=1, fault_sticky=0.
4. TIMEOUT=4, rails held low -> after 4 CHECK cycles plus RECOVERY_CYCLES, r_req=1 with the original data. err_count=1, fault_sticky=1. A separate capture with err1=err0=1 -> shadow word forwarded, fault_sticky=1.
5. Streaming with r_ack=1, l_req=1 and err0 always high -> one word every 2 cycles, in order, none dropped. 300 consecutive err1 events -> err_count saturates at 255. clr_err then zeroes it.
6. Assert rst during RECOVER -> next cycle state EMPTY, r_req=0, l_ack=1. The pending word never appears on r_data, and the counters are cleared.
